ro_job_host: RTL and testbench

Host-side sequencer that drives one job into the ring-oscillator worker and collects its result. It:
- resets the worker;
- serialises a 16-bit start value and a 16-bit count as four strobed bytes;
- waits for the worker's done flag, with a timeout;
- strobes the four result bytes back out and presents them as one 32-bit word.

It sits on the same internal_clock as the worker and connects to the worker's din, shift, done and data-out pins.

---
 rtl/ro_job_host.sv | 137 +++++++++++++
 tb/tb_ro_job_host.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ro_job_host.sv
// ro_job_host: host-side sequencer for one ring-oscillator worker job.
// Resets the worker, loads start/count as four strobed bytes, waits for
// done (with a saturating timeout), then strobes the four result bytes back.
module ro_job_host #(
  parameter int STROBE_CYC = 4,
  parameter int RST_CYC    = 4,
  parameter int TIMEOUT_W  = 20
) (
  input  logic        internal_clock,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] job_start,
  input  logic [15:0] job_count,
  input  logic        worker_done,
  input  logic [7:0]  worker_data,
  output logic        worker_rst,
  output logic        shift,
  output logic [7:0]  dout,
  output logic        busy,
  output logic [31:0] result,
  output logic        result_valid,
  output logic        error
);

  typedef enum logic [3:0] {
    IDLE, RST, LD_SETUP, LD_HIGH, LD_LOW, WAIT, RD_SAMPLE, RD_HIGH, RD_LOW, FIN
  } state_t;

  // One phase counter serves both the reset hold and the strobe phases.
  localparam int MAXC = (STROBE_CYC > RST_CYC) ? STROBE_CYC : RST_CYC;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] S_LAST = CW'(STROBE_CYC - 1);
  localparam logic [CW-1:0] R_LAST = CW'(RST_CYC - 1);

  state_t                state, state_nx;
  logic [CW-1:0]         cnt;
  logic [TIMEOUT_W-1:0]  tcnt;
  logic [1:0]            idx;
  logic [15:0]           start_q, count_q;
  logic                  cnt_last, tmax;

  assign cnt_last = (state == RST) ? (cnt == R_LAST) : (cnt == S_LAST);
  assign tmax     = &tcnt;

  // State register.
  always_ff @(posedge internal_clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic; in WAIT a done flag beats the timeout.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (start) state_nx = RST;
      RST:       if (cnt_last) state_nx = LD_SETUP;
      LD_SETUP:  state_nx = LD_HIGH;
      LD_HIGH:   if (cnt_last) state_nx = LD_LOW;
      LD_LOW:    if (cnt_last) state_nx = (idx == 2'd3) ? WAIT : LD_SETUP;
      WAIT: begin
        if (worker_done) state_nx = RD_SAMPLE;
        else if (tmax)   state_nx = FIN;
      end
      RD_SAMPLE: state_nx = (idx == 2'd3) ? FIN : RD_HIGH;
      RD_HIGH:   if (cnt_last) state_nx = RD_LOW;
      RD_LOW:    if (cnt_last) state_nx = RD_SAMPLE;
      FIN:       state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // Datapath: job latch, phase/timeout counters, byte index, result and error.
  always_ff @(posedge internal_clock) begin
    if (reset) begin
      cnt     <= '0;
      tcnt    <= '0;
      idx     <= '0;
      start_q <= '0;
      count_q <= '0;
      result  <= '0;
      error   <= 1'b0;
    end else begin
      if (state inside {RST, LD_HIGH, LD_LOW, RD_HIGH, RD_LOW})
        cnt <= cnt_last ? '0 : cnt + CW'(1);
      else
        cnt <= '0;
      case (state)
        IDLE: if (start) begin
          start_q <= job_start;
          count_q <= job_count;
          result  <= '0;
          error   <= 1'b0;
          idx     <= '0;
          tcnt    <= '0;
        end
        RST: idx <= '0;
        LD_LOW: if (cnt_last) begin
          if (idx != 2'd3) idx <= idx + 2'd1;
          else             tcnt <= '0;
        end
        WAIT: begin
          if (worker_done) idx <= '0;
          else if (tmax)   error <= 1'b1;
          if (!tmax) tcnt <= tcnt + TIMEOUT_W'(1);
        end
        RD_SAMPLE: begin
          case (idx)
            2'd0: result[31:24] <= worker_data;
            2'd1: result[23:16] <= worker_data;
            2'd2: result[15:8]  <= worker_data;
            default: result[7:0] <= worker_data;
          endcase
        end
        RD_LOW: if (cnt_last) idx <= idx + 2'd1;
        default: ;
      endcase
    end
  end

  // Moore outputs decoded from state; dout only carries a byte in the load states.
  always_comb begin
    busy         = (state != IDLE);
    worker_rst   = (state == RST);
    shift        = (state == LD_HIGH) || (state == RD_HIGH);
    result_valid = (state == FIN);
    dout         = 8'h00;
    if (state inside {LD_SETUP, LD_HIGH, LD_LOW}) begin
      case (idx)
        2'd0:    dout = start_q[15:8];
        2'd1:    dout = start_q[7:0];
        2'd2:    dout = count_q[15:8];
        default: dout = count_q[7:0];
      endcase
    end
  end

endmodule

// File: tb/tb_ro_job_host.sv
// tb_ro_job_host: directed jobs against ro_job_host with a behavioural
// worker, a phase/offset timeline model and hand-computed literal results.
module tb_ro_job_host;
  localparam int S       = 4;
  localparam int R       = 4;
  localparam int TW      = 6;
  localparam int BLEN    = 1 + 2 * S;
  localparam int LOADLEN = R + 4 * BLEN;
  localparam int READLEN = 4 + 6 * S;
  localparam int TMAX    = (1 << TW) - 1;

  logic        internal_clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] job_start = '0, job_count = '0;
  logic        worker_done;
  logic [7:0]  worker_data;
  logic        worker_rst, shift, busy, result_valid, error;
  logic [7:0]  dout;
  logic [31:0] result;

  always #5 internal_clock = ~internal_clock;

  ro_job_host #(.STROBE_CYC(S), .RST_CYC(R), .TIMEOUT_W(TW)) dut (
    .internal_clock(internal_clock), .reset(reset), .start(start),
    .job_start(job_start), .job_count(job_count),
    .worker_done(worker_done), .worker_data(worker_data),
    .worker_rst(worker_rst), .shift(shift), .dout(dout), .busy(busy),
    .result(result), .result_valid(result_valid), .error(error));

  // Behavioural worker: synchronised strobe edge, 4 load bytes, then
  // ca=start+count+1, cb=count+1; each later strobe rotates {ca,cb} by a byte.
  logic [2:0]  wsync;
  logic [2:0]  wnb;
  logic [31:0] wreg;
  logic        wdone;
  logic [3:0]  wdel;
  logic        kill_done = 1'b0;
  always @(posedge internal_clock) begin
    if (reset || worker_rst) begin
      wsync <= '0; wnb <= '0; wreg <= '0; wdone <= 1'b0; wdel <= '0;
    end else begin
      wsync <= {wsync[1:0], shift};
      if (wsync[1] && !wsync[2]) begin
        if (wnb < 3'd4) begin
          wreg <= {wreg[23:0], dout};
          wnb  <= wnb + 3'd1;
        end else if (wdone) wreg <= {wreg[23:0], wreg[31:24]};
      end
      if (wnb == 3'd4 && !wdone) begin
        if (wdel == 4'd5) begin
          wreg  <= {wreg[31:16] + wreg[15:0] + 16'd1, wreg[15:0] + 16'd1};
          wdone <= 1'b1;
        end else wdel <= wdel + 4'd1;
      end
    end
  end
  assign worker_done = wdone & ~kill_done;
  assign worker_data = wreg[31:24];

  // Host model: active flag, phase (0 load, 1 wait, 2 read, 3 fin) and offset.
  int          cyc = 0;
  bit          m_act = 0, m_err = 0;
  int          m_ph = 0, m_k = 0;
  logic [31:0] m_res = '0;
  logic [15:0] m_s = '0, m_c = '0;
  always @(posedge internal_clock) begin
    cyc = cyc + 1;
    if (reset) begin
      m_act = 0; m_err = 0; m_res = '0; m_ph = 0; m_k = 0;
    end else if (!m_act) begin
      if (start) begin
        m_act = 1; m_ph = 0; m_k = 0; m_err = 0; m_res = '0;
        m_s = job_start; m_c = job_count;
      end
    end else begin
      case (m_ph)
        0: if (m_k == LOADLEN - 1) begin m_ph = 1; m_k = 0; end else m_k++;
        1: if (worker_done) begin m_ph = 2; m_k = 0; end
           else if (m_k == TMAX) begin m_ph = 3; m_err = 1; end
           else m_k++;
        2: if (m_k == READLEN - 1) begin
             m_ph = 3; m_res = {m_s + m_c + 16'd1, m_c + 16'd1};
           end else m_k++;
        default: m_act = 0;
      endcase
    end
  end

  int          total = 0, bad = 0;
  bit          chk_en = 0;
  logic        pshift = 1'b0;
  int          nrise = 0, first_rise = 0, t0 = 0;
  logic [7:0]  rq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] ld_byte(input int b);
    case (b)
      0: return m_s[15:8];
      1: return m_s[7:0];
      2: return m_c[15:8];
      default: return m_c[7:0];
    endcase
  endfunction

  task automatic compare();
    logic e_rst, e_shift, e_rv;
    logic [7:0] e_dout;
    int u, p;
    e_rst = 0; e_shift = 0; e_rv = 0; e_dout = '0;
    if (m_act) begin
      case (m_ph)
        0: if (m_k < R) e_rst = 1;
           else begin
             u = m_k - R; p = u % BLEN;
             e_shift = (p >= 1 && p <= S);
             e_dout  = ld_byte(u / BLEN);
           end
        2: begin p = m_k % BLEN; e_shift = (p >= 1 && p <= S); end
        3: e_rv = 1;
        default: ;
      endcase
    end
    chk("busy", busy, m_act);
    chk("worker_rst", worker_rst, e_rst);
    chk("shift", shift, e_shift);
    chk("dout", dout, e_dout);
    chk("result_valid", result_valid, e_rv);
    chk("error", error, m_err);
    if (!(m_act && m_ph == 2)) chk("result", result, m_res);
  endtask

  // Advance one cycle, sample at the falling edge, track strobe rises.
  task automatic step();
    @(negedge internal_clock);
    if (worker_rst) begin nrise = 0; rq.delete(); end
    if (shift && !pshift) begin
      if (nrise == 0) first_rise = cyc;
      nrise++;
      rq.push_back(dout);
    end
    pshift = shift;
    if (chk_en) compare();
  endtask

  task automatic wait_rv();
    int n;
    n = 0;
    while (!result_valid && n < 2000) begin step(); n++; end
    if (!result_valid) chk("rv_wait_expired", 32'd0, 32'd1);
  endtask

  task automatic wait_phase(input int ph, input int k);
    int n;
    n = 0;
    while (!(m_act && m_ph == ph && m_k == k) && n < 500) begin step(); n++; end
    if (!(m_act && m_ph == ph && m_k == k)) chk("phase_wait_expired", 32'd0, 32'd1);
  endtask

  task automatic launch(input logic [15:0] s, input logic [15:0] c);
    job_start = s; job_count = c; start = 1'b1; t0 = cyc;
    step();
    start = 1'b0;
  endtask

  initial begin
    step(); step();
    reset = 1'b0;
    chk_en = 1;
    step();
    chk("rst_busy", busy, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_error", error, 32'd0);
    chk("rst_shift", shift, 32'd0);

    // Basic job and a start pulse coinciding with the FIN cycle.
    launch(16'h1234, 16'h0010);
    wait_rv();
    chk("basic_result", result, 32'h12450011);
    chk("basic_error", error, 32'd0);
    chk("basic_strobes", nrise, 32'd7);
    chk("basic_first_rise", first_rise - t0, 32'd1 + R + 1);
    if (rq.size() >= 4) begin
      chk("basic_b0", rq[0], 32'h12);
      chk("basic_b1", rq[1], 32'h34);
      chk("basic_b2", rq[2], 32'h00);
      chk("basic_b3", rq[3], 32'h10);
    end else chk("basic_rq_size", rq.size(), 32'd4);
    job_start = 16'h9999; start = 1'b1;
    step();
    start = 1'b0;
    chk("fin_start_ignored", busy, 32'd0);
    step();

    // Zero count: ca wraps to 0.
    launch(16'hFFFF, 16'h0000);
    wait_rv();
    chk("zero_result", result, 32'h00000001);
    step();

    // Start pulse during LD_HIGH is ignored.
    launch(16'hABCD, 16'h0102);
    wait_phase(0, R + 2);
    job_start = 16'h1111; job_count = 16'h2222; start = 1'b1;
    step();
    start = 1'b0;
    wait_rv();
    chk("ignored_result", result, 32'hACD00103);
    step();

    // Timeout with done held low.
    kill_done = 1'b1;
    launch(16'h5555, 16'h0001);
    wait_rv();
    chk("to_latency", cyc - t0, 32'd1 + LOADLEN + 64);
    chk("to_error", error, 32'd1);
    chk("to_result", result, 32'd0);
    kill_done = 1'b0;
    step();

    // Reset during RD_HIGH, then a fresh job.
    launch(16'h4321, 16'h0005);
    wait_phase(2, 2);
    reset = 1'b1;
    step();
    chk("midrst_shift", shift, 32'd0);
    chk("midrst_busy", busy, 32'd0);
    chk("midrst_result", result, 32'd0);
    reset = 1'b0;
    step();
    launch(16'h0001, 16'h0002);
    wait_rv();
    chk("after_rst_result", result, 32'h00040003);
    chk("after_rst_error", error, 32'd0);
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
